// File: rtl/bd_reg_pkg.sv
// Shared types and address map for the BD register-field bus sequencer.
// Mapped registers: BD_CONTROL @48, BD_DATA_0 @49, BD_DATA_1 @50.
package bd_reg_pkg;

  localparam logic [7:0] BD_CONTROL_ADDR = 8'd48;
  localparam logic [7:0] BD_DATA_0_ADDR  = 8'd49;
  localparam logic [7:0] BD_DATA_1_ADDR  = 8'd50;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } bd_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } seq_state_t;

  function automatic logic is_mapped(input logic [7:0] addr);
    return (addr == BD_CONTROL_ADDR) ||
           (addr == BD_DATA_0_ADDR)  ||
           (addr == BD_DATA_1_ADDR);
  endfunction

endpackage

// File: rtl/bd_bus_sequencer_if.sv
// Host-side request/response handshake of the BD bus sequencer.
// master = host, slave = sequencer.
interface bd_bus_sequencer_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/bd_req_fifo.sv
// DEPTH-entry request FIFO; pointers carry one extra wrap bit so full/empty
// and the occupancy fall straight out of the pointer difference.
module bd_req_fifo
  import bd_reg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  bd_req_t                      push_data,
  input  logic                         pop,
  output bd_req_t                      pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bd_req_t     mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bd_bus_sequencer.sv
// Upstream master for the BD register field: queues host requests and runs
// them one at a time on the registered address/data/write_enable bus.
module bd_bus_sequencer
  import bd_reg_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  IDLE_ADDR = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  bd_bus_sequencer_if.slave            host,
  output logic                         wr_err,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [7:0]                   bus_address_in,
  output logic [7:0]                   bus_data_in,
  output logic                         bus_write_enable,
  input  logic [7:0]                   bus_address_out,
  input  logic [7:0]                   bus_data_out
);

  seq_state_t state_q, state_d;
  bd_req_t    push_data, head;
  logic       fifo_full, fifo_empty, pop;

  logic [7:0] bus_addr_d, bus_data_d;
  logic       bus_we_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       wr_err_d;

  assign push_data      = '{we: host.req_we, addr: host.req_addr, wdata: host.req_wdata};
  assign host.req_ready = !fifo_full;
  assign host.rsp_valid = (state_q == RESP);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;

  bd_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host.req_valid && !fifo_full),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    bus_addr_d = bus_address_in;
    bus_data_d = bus_data_in;
    bus_we_d   = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wr_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.we) begin
            if (is_mapped(head.addr)) begin
              state_d    = WRITE;
              bus_addr_d = head.addr;
              bus_data_d = head.wdata;
              bus_we_d   = 1'b1;
            end else begin
              wr_err_d = 1'b1;
            end
          end else if (is_mapped(head.addr)) begin
            state_d    = READ;
            bus_addr_d = head.addr;
          end else begin
            state_d    = RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d    = IDLE;
        bus_addr_d = IDLE_ADDR;
      end
      READ: begin
        // bus_address_in still holds the read target here, so it doubles as the echo reference.
        state_d    = RESP;
        bus_addr_d = IDLE_ADDR;
        rsp_data_d = bus_data_out;
        rsp_err_d  = (bus_address_out != bus_address_in);
      end
      RESP: begin
        if (host.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      bus_address_in   <= IDLE_ADDR;
      bus_data_in      <= '0;
      bus_write_enable <= 1'b0;
      rsp_data_q       <= '0;
      rsp_err_q        <= 1'b0;
      wr_err           <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus_address_in   <= bus_addr_d;
      bus_data_in      <= bus_data_d;
      bus_write_enable <= bus_we_d;
      rsp_data_q       <= rsp_data_d;
      rsp_err_q        <= rsp_err_d;
      wr_err           <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_bd_bus_sequencer.sv
// Bench for bd_bus_sequencer: a behavioural register field on the bus side and
// an in-order request model predicting bus writes, wr_err pulses and responses.
module tb_bd_bus_sequencer;

  localparam logic [7:0] IDLE_A = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bd_bus_sequencer_if host_if();

  logic       wr_err;
  logic [2:0] fifo_level;
  logic [7:0] bus_address_in;
  logic [7:0] bus_data_in;
  logic       bus_write_enable;
  logic [7:0] bus_address_out = 8'h00;
  logic [7:0] bus_data_out    = 8'h00;

  bd_bus_sequencer #(
    .DEPTH     (4),
    .IDLE_ADDR (8'h00)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .host             (host_if),
    .wr_err           (wr_err),
    .fifo_level       (fifo_level),
    .bus_address_in   (bus_address_in),
    .bus_data_in      (bus_data_in),
    .bus_write_enable (bus_write_enable),
    .bus_address_out  (bus_address_out),
    .bus_data_out     (bus_data_out)
  );

  // Register field: samples the bus on negedge; outputs hold while the address is unmapped.
  logic [7:0] field [4] = '{default: 8'h00};
  logic       field_corrupt = 1'b0;

  always @(negedge clk) begin
    if (bus_address_in >= 8'd48 && bus_address_in <= 8'd50) begin
      if (bus_write_enable) field[bus_address_in[1:0]] <= bus_data_in;
      bus_address_out <= field_corrupt ? (bus_address_in ^ 8'h01) : bus_address_in;
      bus_data_out    <= bus_write_enable ? bus_data_in : field[bus_address_in[1:0]];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log (only this block writes it).
  logic [7:0]  obs_wr_addr[$], obs_wr_data[$], obs_rsp_data[$];
  logic        obs_rsp_err[$];
  int unsigned obs_wr_cyc[$], obs_rsp_cyc[$];
  int          n_wrerr = 0, n_busy = 0, n_rspv = 0;

  always @(negedge clk) begin
    if (bus_write_enable) begin
      obs_wr_addr.push_back(bus_address_in);
      obs_wr_data.push_back(bus_data_in);
      obs_wr_cyc.push_back(cyc);
    end
    if (bus_address_in != IDLE_A || bus_write_enable) n_busy++;
    if (wr_err) n_wrerr++;
    if (host_if.rsp_valid) n_rspv++;
    if (host_if.rsp_valid && host_if.rsp_ready) begin
      obs_rsp_data.push_back(host_if.rsp_data);
      obs_rsp_err.push_back(host_if.rsp_err);
      obs_rsp_cyc.push_back(cyc);
    end
  end

  // Reference model: register contents and expected effects of each accepted request.
  logic [7:0] shadow [4] = '{default: 8'h00};
  logic [7:0] exp_wr_addr[$], exp_wr_data[$], exp_rsp_data[$];
  logic       exp_rsp_err[$];
  int         exp_wrerr = 0;

  int checks = 0, errors = 0;
  int wr_base, rsp_base, wrerr_base, busy_base, rspv_base;
  bit rand_rdy = 1'b0;

  task automatic model_accept(input logic we, input logic [7:0] addr, input logic [7:0] data);
    bit mapped = (addr >= 8'd48 && addr <= 8'd50);
    if (we) begin
      if (mapped) begin
        shadow[addr[1:0]] = data;
        exp_wr_addr.push_back(addr);
        exp_wr_data.push_back(data);
      end else begin
        exp_wrerr++;
      end
    end else if (mapped) begin
      exp_rsp_data.push_back(shadow[addr[1:0]]);
      exp_rsp_err.push_back(field_corrupt);
    end else begin
      exp_rsp_data.push_back(8'h00);
      exp_rsp_err.push_back(1'b1);
    end
  endtask

  task automatic mark();
    wr_base    = obs_wr_addr.size();
    rsp_base   = obs_rsp_data.size();
    wrerr_base = n_wrerr;
    busy_base  = n_busy;
    rspv_base  = n_rspv;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_rsp_data.delete();
    exp_rsp_err.delete();
    exp_wrerr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) host_if.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_req(input logic we, input logic [7:0] addr, input logic [7:0] data,
                          output bit ok);
    bit acc;
    ok = 1'b0;
    host_if.req_valid = 1'b1;
    host_if.req_we    = we;
    host_if.req_addr  = addr;
    host_if.req_wdata = data;
    for (int i = 0; i < 400; i++) begin
      acc = host_if.req_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    host_if.req_valid = 1'b0;
    if (ok) model_accept(we, addr, data);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(fifo_level == 3'd0 && (obs_rsp_data.size() - rsp_base) >= exp_rsp_data.size())
           && n < 3000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: level %0d rsp %0d of %0d", name, fifo_level,
               obs_rsp_data.size() - rsp_base, exp_rsp_data.size());
    end
  endtask

  task automatic test_reset();
    bit ok;
    mark();
    host_if.rsp_ready = 1'b1;
    push_req(1'b1, 8'd49, 8'h5A, ok);
    drain("reset_setup");
    host_if.rsp_ready = 1'b0;
    push_req(1'b0, 8'd49, 8'h00, ok);
    push_req(1'b0, 8'd50, 8'h00, ok);
    push_req(1'b0, 8'd48, 8'h00, ok);
    repeat (4) tick();
    checks++;
    if (host_if.rsp_valid !== 1'b1 || host_if.rsp_data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_pre_rsp: got valid %b data %h expected 1 5a",
               host_if.rsp_valid, host_if.rsp_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (host_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", host_if.rsp_valid); end
    checks++; if (host_if.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00", host_if.rsp_data); end
    checks++; if (host_if.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", host_if.rsp_err); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (host_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", host_if.req_ready); end
    checks++; if (bus_address_in !== 8'h00) begin errors++; $display("FAIL reset_bus_addr: got %h expected 00", bus_address_in); end
    checks++; if (bus_data_in !== 8'h00) begin errors++; $display("FAIL reset_bus_data: got %h expected 00", bus_data_in); end
    checks++; if (bus_write_enable !== 1'b0) begin errors++; $display("FAIL reset_bus_we: got %b expected 0", bus_write_enable); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    host_if.rsp_ready = 1'b1;
  endtask

  task automatic test_write_read();
    bit ok;
    mark();
    push_req(1'b1, 8'd48, 8'hA5, ok);
    push_req(1'b0, 8'd48, 8'h00, ok);
    drain("write_read");
    checks++;
    if (obs_wr_addr.size() - wr_base !== 1) begin
      errors++; $display("FAIL wr_we_cycles: got %0d expected 1", obs_wr_addr.size() - wr_base);
    end
    checks++;
    if (obs_wr_addr.size() <= wr_base || {obs_wr_addr[wr_base], obs_wr_data[wr_base]} !== {8'd48, 8'hA5}) begin
      errors++; $display("FAIL wr_bus_value: got %0d entries expected 30/a5", obs_wr_addr.size() - wr_base);
    end
    checks++;
    if (obs_rsp_data.size() <= rsp_base || {obs_rsp_data[rsp_base], obs_rsp_err[rsp_base]} !== {8'hA5, 1'b0}) begin
      errors++; $display("FAIL rd_rsp: got %0d responses expected data a5 err 0", obs_rsp_data.size() - rsp_base);
    end else if (obs_rsp_data.size() - rsp_base !== 1) begin
      errors++; $display("FAIL rd_rsp_count: got %0d expected 1", obs_rsp_data.size() - rsp_base);
    end
  endtask

  task automatic test_unmapped();
    bit ok;
    mark();
    push_req(1'b1, 8'h10, 8'h33, ok);
    drain("unmapped_wr");
    checks++;
    if (n_wrerr - wrerr_base !== 1) begin
      errors++; $display("FAIL unmapped_wr_err_cycles: got %0d expected 1", n_wrerr - wrerr_base);
    end
    push_req(1'b0, 8'h10, 8'h00, ok);
    drain("unmapped_rd");
    checks++;
    if (obs_rsp_data.size() - rsp_base !== 1 || obs_rsp_data.size() <= rsp_base ||
        {obs_rsp_data[rsp_base], obs_rsp_err[rsp_base]} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL unmapped_rd_rsp: got %0d responses expected one with data 00 err 1",
                         obs_rsp_data.size() - rsp_base);
    end
    checks++;
    if (n_busy - busy_base !== 0 || obs_wr_addr.size() - wr_base !== 0) begin
      errors++; $display("FAIL unmapped_bus_idle: got %0d busy cycles expected 0", n_busy - busy_base);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit spacing_ok;
    logic [7:0] wa [4] = '{8'd50, 8'd50, 8'd50, 8'd48};
    logic [7:0] wd [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    mark();
    host_if.rsp_ready = 1'b0;
    push_req(1'b0, 8'd49, 8'h00, ok);
    for (int i = 0; i < 4; i++) push_req(1'b1, wa[i], wd[i], ok);
    checks++;
    if (fifo_level !== 3'd4 || host_if.req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: got level %0d ready %b expected 4 0", fifo_level, host_if.req_ready);
    end
    host_if.req_valid = 1'b1;
    host_if.req_we    = 1'b1;
    host_if.req_addr  = 8'd48;
    host_if.req_wdata = 8'hFF;
    repeat (3) tick();
    host_if.req_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL bp_no_fifth: got level %0d expected 4", fifo_level);
    end
    checks++;
    if (host_if.rsp_valid !== 1'b1 || obs_wr_addr.size() - wr_base !== 0) begin
      errors++; $display("FAIL bp_blocked: got rsp_valid %b writes %0d expected 1 0",
                         host_if.rsp_valid, obs_wr_addr.size() - wr_base);
    end
    host_if.rsp_ready = 1'b1;
    drain("backpressure");
    checks++;
    if (obs_wr_addr.size() - wr_base !== 4) begin
      errors++; $display("FAIL bp_write_count: got %0d expected 4", obs_wr_addr.size() - wr_base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({obs_wr_addr[wr_base+i], obs_wr_data[wr_base+i]} !== {wa[i], wd[i]}) begin
          errors++; $display("FAIL bp_write_order[%0d]: got %h/%h expected %h/%h", i,
                             obs_wr_addr[wr_base+i], obs_wr_data[wr_base+i], wa[i], wd[i]);
        end
      end
      spacing_ok = 1'b1;
      for (int i = 0; i < 3; i++)
        if (obs_wr_cyc[wr_base+i+1] - obs_wr_cyc[wr_base+i] != 2) spacing_ok = 1'b0;
      checks++;
      if (!spacing_ok) begin
        errors++; $display("FAIL bp_write_spacing: got cycles %0d %0d %0d %0d expected step 2",
                           obs_wr_cyc[wr_base], obs_wr_cyc[wr_base+1], obs_wr_cyc[wr_base+2], obs_wr_cyc[wr_base+3]);
      end
    end
    checks++;
    if (obs_rsp_data.size() <= rsp_base || exp_rsp_data.size() < 1 ||
        {obs_rsp_data[rsp_base], obs_rsp_err[rsp_base]} !== {exp_rsp_data[0], exp_rsp_err[0]}) begin
      errors++; $display("FAIL bp_read_rsp: got %0d responses expected data 5a err 0", obs_rsp_data.size() - rsp_base);
    end else begin
      checks++;
      if (obs_wr_addr.size() > wr_base && obs_wr_cyc[wr_base] <= obs_rsp_cyc[rsp_base]) begin
        errors++; $display("FAIL bp_read_blocks_writes: got write cycle %0d expected after %0d",
                           obs_wr_cyc[wr_base], obs_rsp_cyc[rsp_base]);
      end
    end
  endtask

  task automatic test_resp_hold();
    bit ok;
    int n;
    int unstable = 0, busy = 0;
    mark();
    host_if.rsp_ready = 1'b0;
    push_req(1'b0, 8'd50, 8'h00, ok);
    for (n = 0; n < 20 && host_if.rsp_valid !== 1'b1; n++) tick();
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL hold_rsp_timeout: got rsp_valid %b expected 1", host_if.rsp_valid);
    end
    for (int i = 0; i < 10; i++) begin
      if (host_if.rsp_valid !== 1'b1 || host_if.rsp_data !== exp_rsp_data[0] || host_if.rsp_err !== 1'b0)
        unstable++;
      if (bus_address_in !== IDLE_A || bus_write_enable !== 1'b0) busy++;
      tick();
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL hold_rsp_stable: got %0d unstable cycles expected 0 (data %h want %h)",
                         unstable, host_if.rsp_data, exp_rsp_data[0]);
    end
    checks++;
    if (busy != 0) begin
      errors++; $display("FAIL hold_bus_idle: got %0d busy cycles expected 0", busy);
    end
    host_if.rsp_ready = 1'b1;
    drain("resp_hold");
    checks++;
    if (obs_rsp_data.size() - rsp_base !== 1) begin
      errors++; $display("FAIL hold_rsp_count: got %0d expected 1", obs_rsp_data.size() - rsp_base);
    end
  endtask

  task automatic test_addr_mismatch();
    bit ok;
    mark();
    field_corrupt = 1'b1;
    push_req(1'b0, 8'd49, 8'h00, ok);
    drain("mismatch");
    field_corrupt = 1'b0;
    checks++;
    if (obs_rsp_data.size() <= rsp_base ||
        {obs_rsp_data[rsp_base], obs_rsp_err[rsp_base]} !== {exp_rsp_data[0], 1'b1}) begin
      errors++; $display("FAIL mismatch_rsp: got %0d responses expected data %h err 1",
                         obs_rsp_data.size() - rsp_base, exp_rsp_data[0]);
    end
  endtask

  task automatic test_reset_during_read();
    bit ok;
    int n;
    mark();
    host_if.rsp_ready = 1'b1;
    push_req(1'b0, 8'd50, 8'h00, ok);
    for (n = 0; n < 10 && bus_address_in !== 8'd50; n++) tick();
    checks++;
    if (n >= 10) begin
      errors++; $display("FAIL rstrd_no_read: got bus addr %h expected 32", bus_address_in);
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (n_rspv - rspv_base !== 0 || obs_rsp_data.size() - rsp_base !== 0) begin
      errors++; $display("FAIL rstrd_rsp_valid: got %0d valid cycles expected 0", n_rspv - rspv_base);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL rstrd_level: got %0d expected 0", fifo_level);
    end
    mark();
    push_req(1'b0, 8'd50, 8'h00, ok);
    drain("reset_during_read");
    checks++;
    if (obs_rsp_data.size() <= rsp_base ||
        {obs_rsp_data[rsp_base], obs_rsp_err[rsp_base]} !== {exp_rsp_data[0], 1'b0}) begin
      errors++; $display("FAIL rstrd_reread: got %0d responses expected data %h err 0",
                         obs_rsp_data.size() - rsp_base, exp_rsp_data[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] tbl [8] = '{8'd48, 8'd49, 8'd50, 8'd48, 8'd50, 8'h10, 8'h00, 8'h33};
    mark();
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push_req(1'($urandom_range(0, 1)), tbl[$urandom_range(0, 7)], 8'($urandom), ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand_push_timeout[%0d]: got not accepted expected accepted", i);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain("random");
    rand_rdy = 1'b0;
    host_if.rsp_ready = 1'b1;
    checks++;
    if (obs_wr_addr.size() - wr_base !== exp_wr_addr.size()) begin
      errors++; $display("FAIL rand_write_count: got %0d expected %0d", obs_wr_addr.size() - wr_base, exp_wr_addr.size());
    end
    for (int i = 0; i < exp_wr_addr.size() && wr_base + i < obs_wr_addr.size(); i++) begin
      checks++;
      if ({obs_wr_addr[wr_base+i], obs_wr_data[wr_base+i]} !== {exp_wr_addr[i], exp_wr_data[i]}) begin
        errors++; $display("FAIL rand_write[%0d]: got %h/%h expected %h/%h", i,
                           obs_wr_addr[wr_base+i], obs_wr_data[wr_base+i], exp_wr_addr[i], exp_wr_data[i]);
      end
    end
    checks++;
    if (obs_rsp_data.size() - rsp_base !== exp_rsp_data.size()) begin
      errors++; $display("FAIL rand_rsp_count: got %0d expected %0d", obs_rsp_data.size() - rsp_base, exp_rsp_data.size());
    end
    for (int i = 0; i < exp_rsp_data.size() && rsp_base + i < obs_rsp_data.size(); i++) begin
      checks++;
      if ({obs_rsp_data[rsp_base+i], obs_rsp_err[rsp_base+i]} !== {exp_rsp_data[i], exp_rsp_err[i]}) begin
        errors++; $display("FAIL rand_rsp[%0d]: got %h/%b expected %h/%b", i,
                           obs_rsp_data[rsp_base+i], obs_rsp_err[rsp_base+i], exp_rsp_data[i], exp_rsp_err[i]);
      end
    end
    checks++;
    if (n_wrerr - wrerr_base !== exp_wrerr) begin
      errors++; $display("FAIL rand_wr_err: got %0d pulses expected %0d", n_wrerr - wrerr_base, exp_wrerr);
    end
  endtask

  initial begin
    host_if.req_valid = 1'b0;
    host_if.req_we    = 1'b0;
    host_if.req_addr  = 8'h00;
    host_if.req_wdata = 8'h00;
    host_if.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    test_reset();
    test_write_read();
    test_unmapped();
    test_backpressure();
    test_resp_hold();
    test_addr_mismatch();
    test_reset_during_read();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
